// File: rtl/hp_au_pkg.sv
// Shared opcode encodings, sequencer state type and BCD limits for the HP AU front end.
package hp_au_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_BCD = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  localparam int unsigned BCD_DIGIT_MAX = 9;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } seq_state_e;

endpackage

// File: rtl/hp_au_issue_seq_if.sv
// Command and response valid/ready channels of the AU issue sequencer.
interface hp_au_issue_seq_if #(
  parameter int unsigned WIDTH = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic [1:0]       cmd_op;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic [1:0]       rsp_op;
  logic             rsp_err;

  // Requester side: issues commands, consumes responses.
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_err
  );

  // Sequencer side.
  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_err
  );

endinterface

// File: rtl/hp_au_cmd_fifo.sv
// Synchronous FIFO with wrap-around pointers and an occupancy count; synchronous reset.
module hp_au_cmd_fifo #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [DataWidth-1:0] wdata,
  input  logic                 pop,
  output logic [DataWidth-1:0] rdata,
  output logic                 full,
  output logic                 empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q;
  logic [PtrW-1:0]      rd_ptr_q;
  logic [CntW-1:0]      count_q;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  // Full blocks a push even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/hp_au_issue_seq.sv
// Registered command sequencer in front of the combinational HP arithmetic unit.
module hp_au_issue_seq
  import hp_au_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  hp_au_issue_seq_if.slave       bus,
  output logic [WIDTH-1:0]       au_a,
  output logic [WIDTH-1:0]       au_b,
  output logic [1:0]             au_sel,
  input  logic [WIDTH-1:0]       au_result,
  output logic                   busy
);

  localparam int unsigned EntryW = 2 * WIDTH + 3;

  logic              full;
  logic              empty;
  logic              push;
  logic              load;
  logic              bcd_bad;
  logic              cmd_err;
  logic [EntryW-1:0] wdata;
  logic [EntryW-1:0] rdata;
  logic [WIDTH-1:0]  head_a;
  logic [WIDTH-1:0]  head_b;
  logic [1:0]        head_op;
  logic              head_err;

  seq_state_e        state_q;
  logic              err_q;
  logic [WIDTH-1:0]  au_a_q;
  logic [WIDTH-1:0]  au_b_q;
  logic [1:0]        au_sel_q;
  logic              rsp_valid_q;
  logic [WIDTH-1:0]  rsp_result_q;
  logic [1:0]        rsp_op_q;
  logic              rsp_err_q;

  // BCD operands must be a single decimal digit with nothing above bit 3.
  always_comb begin
    bcd_bad = (bus.cmd_a[3:0] > 4'(BCD_DIGIT_MAX)) || (bus.cmd_b[3:0] > 4'(BCD_DIGIT_MAX)) ||
              ((bus.cmd_a >> 4) != '0) || ((bus.cmd_b >> 4) != '0);
    cmd_err = (bus.cmd_op == OP_RSV) || ((bus.cmd_op == OP_BCD) && bcd_bad);
  end

  assign bus.cmd_ready = !full && !rst;
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign wdata         = {cmd_err, bus.cmd_op, bus.cmd_b, bus.cmd_a};
  assign {head_err, head_op, head_b, head_a} = rdata;

  // Head is taken from IDLE, or straight out of RESP on a response handshake.
  assign load = !empty && ((state_q == StIdle) || ((state_q == StResp) && bus.rsp_ready));

  hp_au_cmd_fifo #(
    .DataWidth (EntryW),
    .Depth     (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (load),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      err_q        <= 1'b0;
      au_a_q       <= '0;
      au_b_q       <= '0;
      au_sel_q     <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_op_q     <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load) state_q <= StExec;
        end
        StExec: begin
          rsp_valid_q  <= 1'b1;
          rsp_result_q <= (au_sel_q == OP_RSV) ? '0 : au_result;
          rsp_op_q     <= au_sel_q;
          rsp_err_q    <= err_q;
          state_q      <= StResp;
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= load ? StExec : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (load) begin
        au_a_q   <= head_a;
        au_b_q   <= head_b;
        au_sel_q <= head_op;
        err_q    <= head_err;
      end
    end
  end

  assign au_a           = au_a_q;
  assign au_b           = au_b_q;
  assign au_sel         = au_sel_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_op     = rsp_op_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = (state_q != StIdle) || !empty;

endmodule
